// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
  logic req, we, size, busy, done, fault, mem_we;
  logic [31:0] addr, wdata, rdata, mem_a, mem_wd, mem_rd;
  modport master (output req, we, size, addr, wdata, mem_rd, input busy, done, rdata, fault, mem_a, mem_we, mem_wd);
  modport slave (input req, we, size, addr, wdata, mem_rd, output busy, done, rdata, fault, mem_a, mem_we, mem_wd);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: word/byte load-store sequencer with byte-store read-modify-write; `LSU_MISALIGN_FAULT_EN enables misaligned word faults
module load_store_unit #(
  parameter bit LOAD_BYTE_SEXT = 1'b0
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, first_d;
  logic [31:0] addr_q, wdata_q, buf_q, rdata_q;
  logic we_q, size_q, fault_q, accept, mis;
  logic [4:0] sh;
  logic [7:0] lane;
  assign accept = bus.req && (state_q == IDLE || state_q == DONE);
`ifdef LSU_MISALIGN_FAULT_EN
  assign mis = !bus.size && bus.addr[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  assign first_d = mis ? DONE : (bus.we && !bus.size) ? WRITE : READ;
  assign sh = {addr_q[1:0], 3'b000};
  assign lane = 8'(bus.mem_rd >> sh);
  assign bus.busy = state_q == READ || state_q == WRITE;
  assign bus.done = state_q == DONE;
  assign bus.rdata = rdata_q;
  assign bus.fault = fault_q;
  assign bus.mem_a = {addr_q[31:2], 2'b00};
  assign bus.mem_we = state_q == WRITE && !reset;
  assign bus.mem_wd = state_q != WRITE ? '0 : !size_q ? wdata_q : (buf_q & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  // request capture, read buffering, load result and sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      rdata_q <= '0;
      we_q <= 1'b0;
      size_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
        we_q <= bus.we;
        size_q <= bus.size;
      end
      fault_q <= accept && mis;
      if (state_q == READ) begin
        buf_q <= bus.mem_rd;
        if (!we_q) rdata_q <= size_q ? {{24{LOAD_BYTE_SEXT & lane[7]}}, lane} : bus.mem_rd;
      end
      state_q <= accept ? first_d :
                 state_q == READ ? (we_q ? WRITE : DONE) :
                 state_q == WRITE ? DONE :
                 state_q == DONE ? IDLE : state_q;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random checks of load_store_unit against a byte-array memory model
module tb_load_store_unit;
`ifdef LSU_MISALIGN_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk, reset;
  load_store_unit_if bus ();
  load_store_unit_if bus1 ();
  load_store_unit u0 (.clk(clk), .reset(reset), .bus(bus));
  load_store_unit #(.LOAD_BYTE_SEXT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [7:0] rb [1024] = '{default: 8'h0};
  int wr_cnt = 0;
  logic [31:0] wr_addr = 0;
  logic [31:0] rdm = 0;
  int total = 0, bad = 0;
  assign bus.mem_rd = mem[bus.mem_a[9:2]];
  assign bus1.mem_rd = mem[bus1.mem_a[9:2]];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_a[9:2]] <= bus.mem_wd;
      wr_cnt <= wr_cnt + 1;
      wr_addr <= bus.mem_a;
    end
    if (bus1.mem_we) mem[bus1.mem_a[9:2]] <= bus1.mem_wd;
  end
  function automatic logic [31:0] rword(input int a);
    int b = a - a % 4;
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic op(input bit w, input bit sz, input int a, input logic [31:0] d);
    bit mf;
    int lat, w0;
    mf = FE && !sz && (a % 4 != 0);
    w0 = wr_cnt;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_c1", bus.busy, !mf);
      if (bus.done) lat = c;
    end
    chk("latency", lat, mf ? 1 : (w && sz) ? 3 : 2);
    chk("fault", bus.fault, mf);
    if (!mf) begin
      if (w && sz) rb[a] = d[7:0];
      else if (w) for (int k = 0; k < 4; k++) rb[a - a % 4 + k] = d[8*k +: 8];
      else rdm = sz ? {24'h0, rb[a]} : rword(a);
    end
    chk("rdata", bus.rdata, rdm);
    chk("write_count", wr_cnt - w0, (w && !mf) ? 1 : 0);
    if (w && !mf) chk("write_addr", wr_addr, a - a % 4);
  endtask
  task automatic ld1(input int a, input logic [31:0] e);
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.size = 1'b1; bus1.addr = a; bus1.wdata = 0;
    @(posedge clk);
    #1 bus1.req = 1'b0;
    @(negedge clk);
    chk("sext_early_done", bus1.done, 1'b0);
    @(negedge clk);
    chk("sext_done", bus1.done, 1'b1);
    chk("sext_rdata", bus1.rdata, e);
  endtask
  initial begin
    bus.req = 0; bus.we = 0; bus.size = 0; bus.addr = 0; bus.wdata = 0;
    bus1.req = 0; bus1.we = 0; bus1.size = 0; bus1.addr = 0; bus1.wdata = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wd", bus.mem_wd, 0);
    reset = 1'b0;
    op(1, 0, 'h20, 0);
    op(1, 0, 'h20, 32'hDEADBEEF);
    op(0, 0, 'h20, 0);
    chk("plan_word_load", bus.rdata, 32'hDEADBEEF);
    op(1, 0, 'h10, 32'h11223344);
    op(0, 1, 'h12, 0);
    chk("plan_byte_load", bus.rdata, 32'h00000022);
    op(1, 1, 'h11, 32'h000000AB);
    op(0, 0, 'h10, 0);
    chk("plan_byte_store", bus.rdata, 32'h1122AB44);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 1'b1; bus.addr = 'h11; bus.wdata = 'hCD;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_we", bus.mem_we, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rdm = 0;
    chk("abort_done", bus.done, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rdata", bus.rdata, 0);
    chk("abort_mem_a", bus.mem_a, 0);
    chk("abort_mem_wd", bus.mem_wd, 0);
    chk("abort_mem_word", mem[4], 32'h1122AB44);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 1'b0; bus.addr = 'h10;
    @(posedge clk);
    #1 bus.we = 1'b1; bus.addr = 'h40; bus.wdata = 32'h5555;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("busy_req_done", bus.done, 1);
    chk("busy_req_rdata", bus.rdata, 32'h1122AB44);
    @(negedge clk);
    chk("busy_req_no_done_c3", bus.done, 0);
    @(negedge clk);
    chk("busy_req_no_done_c4", bus.done, 0);
    chk("busy_req_no_write", mem[16], 0);
    rdm = 32'h1122AB44;
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 1'b0; bus.addr = 'h20;
    @(posedge clk);
    #1 bus.addr = 'h10;
    @(negedge clk);
    chk("b2b_c1", bus.done, 0);
    @(negedge clk);
    chk("b2b_c2", bus.done, 1);
    chk("b2b_rdata1", bus.rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("b2b_c3", bus.done, 0);
    @(negedge clk);
    chk("b2b_c4", bus.done, 1);
    chk("b2b_rdata2", bus.rdata, 32'h1122AB44);
    op(0, 0, 'h22, 0);
    chk("misalign_rdata", bus.rdata, FE ? 32'h1122AB44 : 32'hDEADBEEF);
    op(1, 0, 'h10, 32'h11228844);
    op(0, 1, 'h11, 0);
    ld1('h11, 32'hFFFFFF88);
    ld1('h12, 32'h00000022);
    for (int i = 0; i < 200; i++) op(1'($urandom), 1'($urandom), $urandom_range(0, 127), $urandom);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), mem[i], rword(4 * i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
